// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 VGA timing constants, lock FSM encoding and the
// per-pixel CRC-16-CCITT step shared by the VGA transmitter and receiver.
package vga_timing_pkg;
    localparam int H_VIS = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int V_VIS = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam logic SYNC_POL = 1'b0;
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} vga_state_e;
    function automatic logic [15:0] crc16_px(input logic [15:0] crc, input logic [11:0] rgb);
        logic [15:0] c;
        c = crc;
        for (int i = 11; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ rgb[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
endpackage

// File: rtl/vga_sync_edge_detect.sv
// vga_sync_edge_detect: two-stage pix_ce sampler for one sync line, with
// assert/deassert pulses issued on the strobe that loads the new level into stage 2.
module vga_sync_edge_detect
    import vga_timing_pkg::*;
#(
    parameter logic POL = SYNC_POL
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_ce_i,
    input  logic sync_i,
    output logic asr_o,
    output logic dea_o
);
    logic s1_q, s2_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= ~POL;
            s2_q <= ~POL;
        end else if (pix_ce_i) begin
            s1_q <= sync_i;
            s2_q <= s1_q;
        end
    end
    assign asr_o = pix_ce_i && (s1_q == POL) && (s2_q != POL);
    assign dea_o = pix_ce_i && (s1_q != POL) && (s2_q == POL);
endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: locks onto incoming VGA timing, recovers x/y, probes one pixel and
// counts dark pixels per frame. Define VGA_RX_FRAME_CRC_EN to add a per-frame CRC-16.
module vga_sync_receiver #(
    parameter int H_VIS = vga_timing_pkg::H_VIS,
    parameter int H_FP = vga_timing_pkg::H_FP,
    parameter int H_SYNC = vga_timing_pkg::H_SYNC,
    parameter int H_BP = vga_timing_pkg::H_BP,
    parameter int V_VIS = vga_timing_pkg::V_VIS,
    parameter int V_FP = vga_timing_pkg::V_FP,
    parameter int V_SYNC = vga_timing_pkg::V_SYNC,
    parameter int V_BP = vga_timing_pkg::V_BP,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    input  logic [9:0]  probe_x,
    input  logic [8:0]  probe_y,
    output logic [9:0]  x_out,
    output logic [8:0]  y_out,
    output logic        active_out,
    output logic        frame_start,
    output logic        locked,
    output logic        lock_err,
    output logic [11:0] probe_color,
    output logic        probe_valid,
    output logic [18:0] dark_count,
    output logic        dark_valid
`ifdef VGA_RX_FRAME_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);
    import vga_timing_pkg::*;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_ACT = H_SYNC + H_BP;
    localparam int V_ACT = V_SYNC + V_BP;
    vga_state_e  state_q, state_d;
    logic [9:0]  h_cnt_q, v_cnt_q;
    logic [11:0] rgb1_q, rgb2_q, probe_color_q;
    logic [18:0] acc_q, dark_count_q;
    logic        frame_start_q, lock_err_q, lock_err_d, probe_valid_q, dark_valid_q;
    logic        hs_asr, hs_dea, vs_asr, vs_dea;
    logic        active, pix_act, last_px, is_dark, mismatch;
    logic [9:0]  x;
    logic [8:0]  y;
    vga_sync_edge_detect #(.POL(SYNC_POL)) u_hs (
        .clk(clk), .reset(reset), .pix_ce_i(pix_ce), .sync_i(hsync_in), .asr_o(hs_asr), .dea_o(hs_dea)
    );
    vga_sync_edge_detect #(.POL(SYNC_POL)) u_vs (
        .clk(clk), .reset(reset), .pix_ce_i(pix_ce), .sync_i(vsync_in), .asr_o(vs_asr), .dea_o(vs_dea)
    );
    // Counters describe the stage-2 sample, so every decode below refers to rgb2_q.
    assign active = h_cnt_q >= 10'(H_ACT) && h_cnt_q < 10'(H_ACT + H_VIS)
                 && v_cnt_q >= 10'(V_ACT) && v_cnt_q < 10'(V_ACT + V_VIS);
    assign locked = state_q == LOCKED;
    assign pix_act = locked && active;
    assign x = h_cnt_q - 10'(H_ACT);
    assign y = 9'(v_cnt_q - 10'(V_ACT));
    assign last_px = pix_act && x == 10'(H_VIS - 1) && y == 9'(V_VIS - 1);
    assign is_dark = rgb2_q == 12'h000;
    assign x_out = pix_act ? x : '0;
    assign y_out = pix_act ? y : '0;
    assign active_out = pix_act;
    assign frame_start = frame_start_q;
    assign lock_err = lock_err_q;
    assign probe_color = probe_color_q;
    assign probe_valid = probe_valid_q;
    assign dark_count = dark_count_q;
    assign dark_valid = dark_valid_q;
    // Sync widths are checked on deassert; vsync deassert shares its strobe with a line start.
    assign mismatch = pix_ce && (
        (hs_asr ? h_cnt_q != 10'(H_TOT - 1) : h_cnt_q == 10'(H_TOT - 1)) ||
        (vs_asr ? v_cnt_q != 10'(V_TOT - 1) : hs_asr && v_cnt_q == 10'(V_TOT - 1)) ||
        (hs_dea && h_cnt_q != 10'(H_SYNC - 1)) ||
        (vs_dea && v_cnt_q + 10'(hs_asr) != 10'(V_SYNC)));
    always_comb begin
        state_d = state_q;
        lock_err_d = 1'b0;
        if (state_q == SEARCH) state_d = vs_asr ? MEASURE : SEARCH;
        else if (mismatch) begin
            state_d = SEARCH;
            lock_err_d = 1'b1;
        end else if (state_q == MEASURE && vs_asr) state_d = LOCKED;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            rgb1_q <= '0;
            rgb2_q <= '0;
            acc_q <= '0;
            probe_color_q <= '0;
            dark_count_q <= '0;
            frame_start_q <= 1'b0;
            lock_err_q <= 1'b0;
            probe_valid_q <= 1'b0;
            dark_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_err_q <= lock_err_d;
            frame_start_q <= vs_asr;
            probe_valid_q <= 1'b0;
            dark_valid_q <= 1'b0;
            if (pix_ce) begin
                rgb1_q <= rgb_in;
                rgb2_q <= rgb1_q;
                h_cnt_q <= hs_asr ? 10'd0 : h_cnt_q + 10'd1;
                v_cnt_q <= vs_asr ? 10'd0 : v_cnt_q + 10'(hs_asr);
                acc_q <= vs_asr ? 19'd0 : acc_q + 19'(pix_act && is_dark);
                if (pix_act && x == probe_x && y == probe_y) begin
                    probe_color_q <= rgb2_q;
                    probe_valid_q <= 1'b1;
                end
                if (last_px) begin
                    dark_count_q <= acc_q + 19'(is_dark);
                    dark_valid_q <= 1'b1;
                end
            end
        end
    end
`ifdef VGA_RX_FRAME_CRC_EN
    logic [15:0] crc_q, frame_crc_q;
    logic        crc_valid_q;
    assign frame_crc = frame_crc_q;
    assign crc_valid = crc_valid_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= 16'hFFFF;
            frame_crc_q <= '0;
            crc_valid_q <= 1'b0;
        end else begin
            crc_valid_q <= 1'b0;
            if (pix_ce) begin
                crc_q <= vs_asr ? 16'hFFFF : pix_act ? crc16_px(crc_q, rgb2_q) : crc_q;
                if (last_px) begin
                    frame_crc_q <= crc16_px(crc_q, rgb2_q);
                    crc_valid_q <= 1'b1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: drives a reduced-size VGA raster into vga_sync_receiver and
// scoreboards probe, dark-count and (optionally) CRC results plus lock behaviour.
module tb_vga_sync_receiver;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
    localparam int HA = HS + HB, VA = VS + VB;
    localparam int PX = 5, PY = 3;

    logic        clk, reset, pix_ce, hsync_in, vsync_in;
    logic [11:0] rgb_in;
    logic [9:0]  probe_x;
    logic [8:0]  probe_y;
    logic [9:0]  x_out;
    logic [8:0]  y_out;
    logic        active_out, frame_start, locked, lock_err, probe_valid, dark_valid;
    logic [11:0] probe_color;
    logic [18:0] dark_count;
`ifdef VGA_RX_FRAME_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    vga_sync_receiver #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y), .x_out(x_out), .y_out(y_out),
        .active_out(active_out), .frame_start(frame_start), .locked(locked), .lock_err(lock_err),
        .probe_color(probe_color), .probe_valid(probe_valid), .dark_count(dark_count),
        .dark_valid(dark_valid)
`ifdef VGA_RX_FRAME_CRC_EN
        , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int lerr_cnt = 0, fs_cnt = 0, xmin = 1023, xmax = 0, ymax = 0;
    logic [11:0] pq[$];
    logic [18:0] dq[$];
    logic [15:0] cq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int b = 11; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r = r << 1;
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [11:0] color(input int mode, input int x, input int y);
        if (mode == 0) return 12'h000;
        if (mode == 1) return 12'hFFF;
        if (x == PX && y == PY) return 12'h0F0;
        return ((x + y) % 3 == 0) ? 12'h000 : 12'(x * 16 + y + 1);
    endfunction

    task automatic pix(input logic h, input logic v, input logic [11:0] c);
        hsync_in = h;
        vsync_in = v;
        rgb_in = c;
        pix_ce = 1'b1;
        @(posedge clk);
        #1 pix_ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int mode, input bit exp_lock, input int short_line = -1,
                         input bit vstuck = 1'b0, input int nlines = VT);
        int dark, x, y;
        bit act;
        logic [11:0] c;
        logic [15:0] crc;
        dark = 0;
        crc = 16'hFFFF;
        for (int v = 0; v < nlines; v++) begin
            for (int h = 0; h < ((v == short_line) ? HT - 1 : HT); h++) begin
                act = h >= HA && h < HA + HV && v >= VA && v < VA + VV;
                x = h - HA;
                y = v - VA;
                c = act ? color(mode, x, y) : 12'h000;
                if (act) begin
                    dark += int'(c == 12'h000);
                    crc = crc_ref(crc, c);
                    if (exp_lock && (short_line < 0 || v <= short_line)
                        && x == int'(probe_x) && y == int'(probe_y))
                        pq.push_back(c);
                    if (exp_lock && short_line < 0 && x == HV - 1 && y == VV - 1) begin
                        dq.push_back(19'(dark));
`ifdef VGA_RX_FRAME_CRC_EN
                        cq.push_back(crc);
`endif
                    end
                end
                pix((h < HS) ? 1'b0 : 1'b1, (vstuck || v < VS) ? 1'b0 : 1'b1, c);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (lock_err) lerr_cnt++;
            if (frame_start) fs_cnt++;
            if (active_out) begin
                if (int'(x_out) < xmin) xmin = int'(x_out);
                if (int'(x_out) > xmax) xmax = int'(x_out);
                if (int'(y_out) > ymax) ymax = int'(y_out);
            end
            if (probe_valid) begin
                chk("probe_pending", 32'(pq.size() != 0), 1);
                if (pq.size() != 0) chk("probe_color", probe_color, pq.pop_front());
            end
            if (dark_valid) begin
                chk("dark_pending", 32'(dq.size() != 0), 1);
                if (dq.size() != 0) chk("dark_count", dark_count, dq.pop_front());
            end
`ifdef VGA_RX_FRAME_CRC_EN
            if (crc_valid) begin
                chk("crc_pending", 32'(cq.size() != 0), 1);
                if (cq.size() != 0) chk("frame_crc", frame_crc, cq.pop_front());
            end
`endif
        end
    end

    initial begin
        reset = 1'b1;
        pix_ce = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        rgb_in = '0;
        probe_x = 10'(PX);
        probe_y = 9'(PY);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_active", active_out, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lerr", lock_err, 0);
        chk("rst_probe", probe_color, 0);
        chk("rst_dark", dark_count, 0);
        reset = 1'b0;

        frame(0, 1'b0);
        chk("f1_unlocked", locked, 0);
        xmin = 1023; xmax = 0; ymax = 0;
        frame(2, 1'b1);
        chk("f2_locked", locked, 1);
        chk("f2_no_lerr", lerr_cnt, 0);
        chk("f2_fs_cnt", fs_cnt, 2);
        chk("f2_xmin", xmin, 0);
        chk("f2_xmax", xmax, HV - 1);
        chk("f2_ymax", ymax, VV - 1);
        chk("f2_probe", probe_color, 12'h0F0);

        frame(2, 1'b1, -1, 1'b0, 6);
        chk("mid_locked", locked, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_probe", probe_color, 0);
        chk("mid_rst_dark", dark_count, 0);
        chk("mid_rst_valid", dark_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        frame(1, 1'b0);
        chk("relock_not_early", locked, 0);
        frame(1, 1'b1);
        chk("relock", locked, 1);
        chk("dark_white", dark_count, 0);
        frame(0, 1'b1);
        chk("dark_black", dark_count, HV * VV);

        frame(2, 1'b1, 10);
        chk("short_lerr", lerr_cnt, 1);
        chk("short_unlocked", locked, 0);
        frame(2, 1'b0);
        chk("short_measure", locked, 0);
        frame(2, 1'b1);
        chk("short_relock", locked, 1);

        probe_x = 10'(HV);
        frame(2, 1'b1);
        chk("oor_probe_hold", probe_color, 12'h0F0);
        probe_x = 10'(PX);

        frame(0, 1'b1, -1, 1'b1);
        chk("vstuck_pre_lerr", lerr_cnt, 1);
        frame(0, 1'b0);
        chk("vstuck_lerr", lerr_cnt, 2);
        chk("vstuck_unlocked", locked, 0);
        frame(0, 1'b0);
        frame(0, 1'b1);
        chk("vstuck_relock", locked, 1);

        repeat (8) @(posedge clk);
        #1;
        chk("probe_q_empty", pq.size(), 0);
        chk("dark_q_empty", dq.size(), 0);
`ifdef VGA_RX_FRAME_CRC_EN
        chk("crc_q_empty", cq.size(), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
